// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier bus initiator: register map, CTL bits,
// sequencer and transfer-phase encodings.
package mul_pkg;

  localparam logic [31:0] MUL_A   = 32'h00;
  localparam logic [31:0] MUL_B   = 32'h04;
  localparam logic [31:0] MUL_PL  = 32'h08;
  localparam logic [31:0] MUL_PH  = 32'h0C;
  localparam logic [31:0] MUL_CTL = 32'h10;

  // START (on write) and BUSY (on read) share bit 0
  localparam int CTL_START = 0;
  localparam int CTL_BUSY  = 0;
  localparam int CTL_UNS   = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WR_GO,
    S_SETTLE,
    S_POLL,
    S_RD_PL,
    S_RD_PH,
    S_WR_CLR,
    S_RESP
  } seq_state_t;

  typedef enum logic {
    PH_ISSUE,
    PH_GAP
  } xfer_phase_t;

  function automatic logic [31:0] ctl_word(input logic uns, input logic go);
    logic [31:0] w;
    w = '0;
    w[CTL_UNS]   = uns;
    w[CTL_START] = go;
    return w;
  endfunction

endpackage

// File: rtl/mul_initiator_bus_xfer.sv
// Single-transfer engine for the c_* valid/ready bus: holds the request until
// acknowledged, then waits out the trailing ready before reporting done.
module bus_xfer
  import mul_pkg::*;
#(
  parameter int BUS_TO = 16
) (
  input  logic        c_clk,
  input  logic        c_rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        timeout,
  output logic        c_valid,
  output logic        c_write,
  output logic [31:0] c_addr,
  output logic [31:0] c_wdata,
  input  logic        c_ready,
  input  logic [31:0] c_rdata
);

  localparam int TW = $clog2(BUS_TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUS_TO - 1);

  logic           active_reg;
  xfer_phase_t    phase_reg;
  logic [TW-1:0]  to_cnt_reg;
  logic           c_valid_reg;
  logic           c_write_reg;
  logic [31:0]    c_addr_reg;
  logic [31:0]    c_wdata_reg;
  logic [31:0]    rdata_reg;
  logic           done_reg;
  logic           timeout_reg;

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      active_reg  <= 1'b0;
      phase_reg   <= PH_ISSUE;
      to_cnt_reg  <= '0;
      c_valid_reg <= 1'b0;
      c_write_reg <= 1'b0;
      c_addr_reg  <= '0;
      c_wdata_reg <= '0;
      rdata_reg   <= '0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      if (!active_reg) begin
        if (start) begin
          active_reg  <= 1'b1;
          phase_reg   <= PH_ISSUE;
          to_cnt_reg  <= '0;
          c_valid_reg <= 1'b1;
          c_write_reg <= write;
          c_addr_reg  <= addr;
          c_wdata_reg <= wdata;
        end
      end else if (phase_reg == PH_ISSUE) begin
        if (c_ready) begin
          if (!c_write_reg) rdata_reg <= c_rdata;
          c_valid_reg <= 1'b0;
          phase_reg   <= PH_GAP;
        end else if (to_cnt_reg == TO_LAST) begin
          // abort without a gap: the slave never answered
          c_valid_reg <= 1'b0;
          active_reg  <= 1'b0;
          done_reg    <= 1'b1;
          timeout_reg <= 1'b1;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end else if (!c_ready) begin
        active_reg <= 1'b0;
        done_reg   <= 1'b1;
      end
    end
  end

  assign c_valid = c_valid_reg;
  assign c_write = c_write_reg;
  assign c_addr  = c_addr_reg;
  assign c_wdata = c_wdata_reg;
  assign rdata   = rdata_reg;
  assign done    = done_reg;
  assign timeout = timeout_reg;

endmodule

// File: rtl/mul_initiator.sv
// Bus initiator that runs the full multiplier register sequence for one
// upstream request and returns the 64-bit product or an error.
module mul_initiator
  import mul_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0,
  parameter int          SETTLE_CYC = 4,
  parameter int          POLL_MAX   = 64,
  parameter int          BUS_TO     = 16
) (
  input  logic        c_clk,
  input  logic        c_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_uns,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_p,
  output logic        rsp_err,
  output logic        c_valid,
  output logic        c_write,
  output logic [31:0] c_addr,
  output logic [1:0]  c_size,
  output logic [31:0] c_wdata,
  input  logic        c_ready,
  input  logic [31:0] c_rdata
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_MAX - 1);

  seq_state_t     state_reg;
  logic           issued_reg;
  logic           xfer_start_reg;
  logic [31:0]    xfer_addr_reg;
  logic           xfer_write_reg;
  logic [31:0]    xfer_wdata_reg;
  logic [31:0]    a_reg;
  logic [31:0]    b_reg;
  logic           uns_reg;
  logic [63:0]    p_reg;
  logic           err_reg;
  logic [SW-1:0]  settle_cnt_reg;
  logic [PW-1:0]  poll_cnt_reg;
  logic           req_ready_reg;
  logic           rsp_valid_reg;

  logic           xfer_done;
  logic           xfer_timeout;
  logic [31:0]    xfer_rdata;

  logic [31:0]    acc_off;
  logic           acc_write;
  logic [31:0]    acc_wdata;

  // Register access implied by the current bus state
  always_comb begin
    acc_off   = MUL_A;
    acc_write = 1'b1;
    acc_wdata = a_reg;
    case (state_reg)
      S_WR_B:   begin acc_off = MUL_B;   acc_wdata = b_reg; end
      S_WR_GO:  begin acc_off = MUL_CTL; acc_wdata = ctl_word(uns_reg, 1'b1); end
      S_POLL:   begin acc_off = MUL_CTL; acc_write = 1'b0; acc_wdata = '0; end
      S_RD_PL:  begin acc_off = MUL_PL;  acc_write = 1'b0; acc_wdata = '0; end
      S_RD_PH:  begin acc_off = MUL_PH;  acc_write = 1'b0; acc_wdata = '0; end
      S_WR_CLR: begin acc_off = MUL_CTL; acc_wdata = ctl_word(uns_reg, 1'b0); end
      default:  ;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state_reg      <= S_IDLE;
      issued_reg     <= 1'b0;
      xfer_start_reg <= 1'b0;
      xfer_addr_reg  <= '0;
      xfer_write_reg <= 1'b0;
      xfer_wdata_reg <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      uns_reg        <= 1'b0;
      p_reg          <= '0;
      err_reg        <= 1'b0;
      settle_cnt_reg <= '0;
      poll_cnt_reg   <= '0;
      req_ready_reg  <= 1'b1;
      rsp_valid_reg  <= 1'b0;
    end else begin
      xfer_start_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req_valid && req_ready_reg) begin
            a_reg         <= req_a;
            b_reg         <= req_b;
            uns_reg       <= req_uns;
            p_reg         <= '0;
            err_reg       <= 1'b0;
            issued_reg    <= 1'b0;
            req_ready_reg <= 1'b0;
            state_reg     <= S_WR_A;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            poll_cnt_reg <= '0;
            state_reg    <= S_POLL;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          if (!issued_reg) begin
            issued_reg     <= 1'b1;
            xfer_start_reg <= 1'b1;
            xfer_addr_reg  <= BASE + acc_off;
            xfer_write_reg <= acc_write;
            xfer_wdata_reg <= acc_wdata;
          end else if (xfer_done) begin
            issued_reg <= 1'b0;
            if (xfer_timeout) begin
              err_reg       <= 1'b1;
              p_reg         <= '0;
              rsp_valid_reg <= 1'b1;
              state_reg     <= S_RESP;
            end else begin
              case (state_reg)
                S_WR_A:  state_reg <= S_WR_B;
                S_WR_B:  state_reg <= S_WR_GO;
                S_WR_GO: begin
                  settle_cnt_reg <= '0;
                  state_reg      <= S_SETTLE;
                end
                S_POLL: begin
                  if (!xfer_rdata[CTL_BUSY]) begin
                    state_reg <= S_RD_PL;
                  end else if (poll_cnt_reg == POLL_LAST) begin
                    err_reg   <= 1'b1;
                    p_reg     <= '0;
                    state_reg <= S_WR_CLR;
                  end else begin
                    poll_cnt_reg <= poll_cnt_reg + 1'b1;
                  end
                end
                S_RD_PL: begin
                  p_reg[31:0] <= xfer_rdata;
                  state_reg   <= S_RD_PH;
                end
                S_RD_PH: begin
                  p_reg[63:32] <= xfer_rdata;
                  state_reg    <= S_WR_CLR;
                end
                S_WR_CLR: begin
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= S_RESP;
                end
                default: state_reg <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  bus_xfer #(
    .BUS_TO (BUS_TO)
  ) u_xfer (
    .c_clk   (c_clk),
    .c_rst   (c_rst),
    .start   (xfer_start_reg),
    .addr    (xfer_addr_reg),
    .write   (xfer_write_reg),
    .wdata   (xfer_wdata_reg),
    .done    (xfer_done),
    .rdata   (xfer_rdata),
    .timeout (xfer_timeout),
    .c_valid (c_valid),
    .c_write (c_write),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_ready (c_ready),
    .c_rdata (c_rdata)
  );

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_p     = p_reg;
  assign rsp_err   = err_reg;
  assign c_size    = 2'b10;

endmodule

// File: tb/tb_mul_initiator.sv
// Scoreboard bench for mul_initiator against a behavioural multiplier slave.
module tb_mul_initiator;

  logic        c_clk = 1'b0;
  logic        c_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_uns = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_p;
  logic        rsp_err;
  logic        c_valid;
  logic        c_write;
  logic [31:0] c_addr;
  logic [1:0]  c_size;
  logic [31:0] c_wdata;
  logic        c_ready = 1'b0;
  logic [31:0] c_rdata = '0;

  always #5 c_clk = ~c_clk;

  mul_initiator #(
    .BASE       (32'h0),
    .SETTLE_CYC (4),
    .POLL_MAX   (4),
    .BUS_TO     (16)
  ) dut (
    .c_clk     (c_clk),
    .c_rst     (c_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_uns   (req_uns),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err),
    .c_valid   (c_valid),
    .c_write   (c_write),
    .c_addr    (c_addr),
    .c_size    (c_size),
    .c_wdata   (c_wdata),
    .c_ready   (c_ready),
    .c_rdata   (c_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t        log_q[$];
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic        s_uns = 1'b0;
  int          s_busy = 0;
  logic [63:0] s_prod = '0;
  logic        mute = 1'b0;
  logic        stuck = 1'b0;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b, input logic uns);
    logic signed [63:0] x;
    logic signed [63:0] y;
    if (uns) return {32'b0, a} * {32'b0, b};
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] addr);
    case (addr)
      32'h00:  return s_a;
      32'h04:  return s_b;
      32'h08:  return s_prod[31:0];
      32'h0C:  return s_prod[63:32];
      32'h10:  return {30'b0, s_uns, (stuck || s_busy > 0)};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge c_clk) begin
    if (c_rst) begin
      c_ready <= 1'b0;
    end else begin
      if (s_busy > 0) s_busy <= s_busy - 1;
      c_ready <= c_valid && !c_ready && !mute;
      if (c_valid && !c_ready && !mute) begin
        if (c_write) begin
          log_q.push_back({1'b1, c_addr, c_wdata});
          case (c_addr)
            32'h00: s_a <= c_wdata;
            32'h04: s_b <= c_wdata;
            32'h10: begin
              s_uns <= c_wdata[1];
              if (c_wdata[0]) begin
                s_busy <= 12;
                s_prod <= smul(s_a, s_b, c_wdata[1]);
              end
            end
            default: ;
          endcase
        end else begin
          log_q.push_back({1'b0, c_addr, slave_read(c_addr)});
          c_rdata <= slave_read(c_addr);
        end
      end
    end
  end

  // ---------------- bus observers ----------------
  logic prev_ack = 1'b0;
  int   gap_viol = 0;
  int   valid_cyc = 0;

  always @(negedge c_clk) begin
    if (prev_ack && c_valid) gap_viol++;
    prev_ack = c_valid && c_ready;
    if (c_valid) valid_cyc++;
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct packed {
    logic [63:0] p;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   rsp_seen = 0;

  always @(negedge c_clk) begin
    rsp_t e;
    if (!c_rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_p", rsp_p, e.p);
        chk("rsp_err", rsp_err, e.err);
        $display("rsp %0d: p=%h err=%0b", rsp_seen, rsp_p, rsp_err);
      end
      rsp_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic uns);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge c_clk); #1;
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    $display("req: a=%h b=%h uns=%0b", a, b, uns);
    req_a = a;
    req_b = b;
    req_uns = uns;
    req_valid = 1'b1;
    @(posedge c_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_seen < target && n < 2000) begin
      @(posedge c_clk); #1;
      n++;
    end
    chk("rsp_wait", (rsp_seen >= target), 1);
  endtask

  task automatic chk_acc(input string name, input int idx, input logic w,
                         input logic [31:0] addr, input logic [31:0] data);
    if (idx < 0 || idx >= log_q.size()) chk(name, 65'h1_FFFF_FFFF_FFFF_FFFF, {w, addr, data});
    else chk(name, log_q[idx], {w, addr, data});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [63:0] held_p;

    repeat (3) @(posedge c_clk);
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_c_valid", c_valid, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_c_size", c_size, 2'b10);
    chk("reset_rsp_p", rsp_p, 0);
    c_rst = 1'b0;
    @(posedge c_clk); #1;

    // unsigned 3*5 with full trace check
    log_q.delete();
    gap_viol = 0;
    exp_q.push_back({64'h0000_0000_0000_000F, 1'b0});
    do_req(32'd3, 32'd5, 1'b1);
    wait_rsp(1);
    n = log_q.size();
    chk_acc("u_wr_a", 0, 1'b1, 32'h00, 32'd3);
    chk_acc("u_wr_b", 1, 1'b1, 32'h04, 32'd5);
    chk_acc("u_wr_go", 2, 1'b1, 32'h10, 32'h3);
    chk_acc("u_last_poll", n - 4, 1'b0, 32'h10, 32'h2);
    chk_acc("u_rd_pl", n - 3, 1'b0, 32'h08, 32'hF);
    chk_acc("u_rd_ph", n - 2, 1'b0, 32'h0C, 32'h0);
    chk_acc("u_wr_clr", n - 1, 1'b1, 32'h10, 32'h2);
    bad = 0;
    for (int i = 3; i < n - 3; i++) if (log_q[i].w || log_q[i].addr != 32'h10) bad++;
    chk("u_poll_trace", bad, 0);
    chk("u_poll_count", (n - 6 >= 1 && n - 6 <= 4), 1);
    chk("u_gap", gap_viol, 0);

    // signed -7*6
    log_q.delete();
    exp_q.push_back({64'hFFFF_FFFF_FFFF_FFD6, 1'b0});
    do_req(32'hFFFF_FFF9, 32'd6, 1'b0);
    wait_rsp(2);
    n = log_q.size();
    chk_acc("s_wr_go", 2, 1'b1, 32'h10, 32'h1);
    chk_acc("s_wr_clr", n - 1, 1'b1, 32'h10, 32'h0);
    chk("s_gap", gap_viol, 0);

    // poll timeout: slave stays busy
    log_q.delete();
    stuck = 1'b1;
    exp_q.push_back({64'h0, 1'b1});
    do_req(32'd7, 32'd9, 1'b0);
    wait_rsp(3);
    stuck = 1'b0;
    chk("pt_count", log_q.size(), 8);
    for (int i = 3; i < 7; i++) chk_acc("pt_poll", i, 1'b0, 32'h10, 32'h1);
    chk_acc("pt_clr", 7, 1'b1, 32'h10, 32'h0);

    // bus timeout: slave never acknowledges
    log_q.delete();
    mute = 1'b1;
    valid_cyc = 0;
    exp_q.push_back({64'h0, 1'b1});
    do_req(32'd1, 32'd1, 1'b1);
    wait_rsp(4);
    repeat (6) @(posedge c_clk);
    #1;
    chk("bt_valid_cycles", valid_cyc, 16);
    chk("bt_no_acc", log_q.size(), 0);
    chk("bt_req_ready", req_ready, 1);
    mute = 1'b0;

    // response backpressure
    rsp_ready = 1'b0;
    exp_q.push_back({64'h0000_0000_0000_000F, 1'b0});
    do_req(32'd3, 32'd5, 1'b1);
    n = 0;
    while (!rsp_valid && n < 2000) begin
      @(posedge c_clk); #1;
      n++;
    end
    held_p = rsp_p;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_p", rsp_p, 64'hF);
      chk("bp_p_stable", rsp_p, held_p);
      @(posedge c_clk); #1;
    end
    rsp_ready = 1'b1;
    wait_rsp(5);

    // reset while polling, no response expected for that request
    do_req(32'd2, 32'd2, 1'b1);
    n = 0;
    while (!(c_valid && !c_write && c_addr == 32'h10) && n < 500) begin
      @(posedge c_clk); #1;
      n++;
    end
    chk("rst_poll_seen", (c_valid && !c_write && c_addr == 32'h10), 1);
    c_rst = 1'b1;
    @(posedge c_clk); #1;
    chk("rst_c_valid", c_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    c_rst = 1'b0;

    exp_q.push_back({64'hFFFF_FFFE_0000_0001, 1'b0});
    do_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_rsp(6);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_initiator.md
Name: mul_initiator

Overview:
- Bus initiator (master) for the memory-mapped multiplier peripheral on the c_* valid/ready bus.
- Accepts a multiply request (a, b, signedness) on an upstream valid/ready port and runs the full register sequence on the c_* bus: write A, write B, write CTL start, settle, poll CTL busy, read P_L/P_H, write CTL clear.
- Returns the 64-bit product, or an error, on a response port.
- Sits between a CPU-side accelerator wrapper and the multiplier's register slave.

Parameters:
- BASE, 32'h0, byte base address of the multiplier register block (A=+0x00, B=+0x04, P_L=+0x08, P_H=+0x0C, CTL=+0x10).
- SETTLE_CYC, 4, c_clk cycles to wait after the CTL start write before the first poll; covers the fclk-domain start latency.
- POLL_MAX, 64, maximum CTL poll reads before the sequence aborts with an error.
- BUS_TO, 16, maximum cycles c_valid may stay high without c_ready before the sequence aborts with an error.

Ports:
- c_clk  in  1  single clock for the whole block.
- c_rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_a  in  32  multiplicand.
- req_b  in  32  multiplier.
- req_uns  in  1  1 = unsigned, 0 = signed.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_p  out  64  product, {P_H, P_L}.
- rsp_err  out  1  1 = bus timeout or poll timeout.
- c_valid  out  1  bus request.
- c_write  out  1  1 = write, 0 = read.
- c_addr  out  32  word-aligned byte address.
- c_size  out  2  always 2'b10 (32-bit).
- c_wdata  out  32  write data.
- c_ready  in  1  slave acknowledge; the slave registers c_valid, so read data arrives with c_ready.
- c_rdata  in  32  read data, valid while c_ready=1.

Behaviour:
- Reset (synchronous, c_rst=1 at a c_clk edge):
  - Next state is IDLE; all outputs 0 except req_ready=1 and c_size=2'b10.
  - Applies even mid-sequence: c_valid drops at that same edge. No CTL clear is issued; the slave's start bit remains stale.
- Handshake: req accepted when req_valid && req_ready. a, b and uns are latched, and req_ready drops at the next edge.
- Bus transfer, per access:
  - ISSUE: drive c_valid=1 with c_addr, c_write and c_wdata stable until c_ready=1 is sampled. On a read, capture c_rdata in that same cycle.
  - GAP: drive c_valid=0 and wait until c_ready=0 is sampled, so the trailing ready from the held valid is never taken as the next acknowledge.
  - Minimum cost per access is 3 cycles (ISSUE 2, GAP 1).
  - Timeout: a BUS_TO counter runs during ISSUE. On expiry, drop c_valid, set err, and go to RESP (the GAP is skipped).
- Sequence FSM: IDLE -> WR_A -> WR_B -> WR_GO -> SETTLE -> POLL -> RD_PL -> RD_PH -> WR_CLR -> RESP -> IDLE.
  - WR_A: write a to BASE+0x00.
  - WR_B: write b to BASE+0x04.
  - WR_GO: write CTL = {30'b0, uns, 1'b1}.
  - SETTLE: count SETTLE_CYC cycles with c_valid=0.
  - POLL: read CTL. If bit0=1, re-read. If bit0=0, go to RD_PL. After POLL_MAX reads with bit0 still 1, set err and go to WR_CLR.
  - RD_PL: read BASE+0x08 into p[31:0].
  - RD_PH: read BASE+0x0C into p[63:32].
  - WR_CLR: write CTL = {30'b0, uns, 1'b0}. This state is always executed unless the error was a bus timeout.
  - RESP: rsp_valid=1; rsp_p and rsp_err are held stable until rsp_ready. Then go to IDLE, and req_ready rises next cycle.
- On error, rsp_p = 64'h0.
- a and b are not rewritten between the start write and the result reads, because the slave derives the sign fix-up from them.
- req_valid arriving while busy is ignored; no queueing.

Decomposition:
- Package mul_pkg holds:
  - Register offsets: MUL_A=0x00, MUL_B=0x04, MUL_PL=0x08, MUL_PH=0x0C, MUL_CTL=0x10.
  - CTL bit indices: START/BUSY=0, UNS=1.
  - Sequence-FSM state enum.
  - Transfer-phase enum: ISSUE, GAP.
- One sub-module, bus_xfer: a single-transfer engine.
  - Inputs: start, addr, write, wdata.
  - Outputs: done, rdata, timeout.
  - Owns the ISSUE/GAP phases and the BUS_TO counter. Reusable by other initiators.

Test Plan:
- Unsigned: a=3, b=5, uns=1 -> rsp_p=64'h000000000000000F, rsp_err=0. The bus trace is exactly the writes/reads in sequence order, with c_valid low for ≥1 cycle between accesses.
- Signed: a=-7 (0xFFFFFFF9), b=6, uns=0 -> rsp_p=64'hFFFFFFFFFFFFFFD6. The CTL start write data is 0x1, the clear write data is 0x0.
- Poll timeout: slave model reports busy=1 forever, POLL_MAX=4 -> exactly 4 CTL reads, then a CTL clear write of 0x0 (uns=0), then rsp_err=1 with rsp_p=0.
- Bus timeout: slave never asserts c_ready, BUS_TO=16 -> c_valid falls after 16 cycles on the WR_A access. rsp_err=1, no further bus activity, req_ready=1 after the response.
- Backpressure and reset: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_p stable throughout. Then assert c_rst during POLL -> c_valid=0 and req_ready=1 on the next edge. A following request 0xFFFFFFFF*0xFFFFFFFF, uns=1 -> 64'hFFFFFFFE00000001.
